// File: rtl/spike_aer_encoder.sv
// Purpose : buffers parallel post-neuron spike words and serializes each set bit onto a 4-phase AER link.
// Latency : word pushed into an empty FIFO at edge 0 is popped at edge 1; REQ is registered high after edge 2.
// Backpressure: SPK_READY drops when the FIFO is full; non-zero words offered while full are dropped and counted.
//
// Ports:
//   CLK, RST                 core clock, async active-high reset
//   SPK_VALID/SPK_VEC/SPK_WORD_ADDR  spike word input (bit i = neuron {word_addr,i})
//   SPK_READY                FIFO not full
//   AEROUT_ADDR/REQ/ACK      AER output link (ACK asynchronous to CLK)
//   OVF_CNT                  saturating count of dropped non-zero words
//   BUSY                     FIFO non-empty or handshake engine active

// Purpose : generic single-clock FIFO with a registered occupancy count.
// Latency : pushed entry is visible on pop_dat the edge after the push.
// Backpressure: pushes while full are ignored; pops while empty are ignored.
module spike_aer_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  // One extra bit so a full FIFO is distinguishable from an empty one.
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module spike_aer_encoder #(
  parameter int POST_NEUR_PARALLEL        = 4,
  parameter int POST_NEUR_WORD_ADDR_WIDTH = 8,
  parameter int POST_NEUR_BYTE_ADDR_WIDTH = 2,
  parameter int AER_WIDTH                 = 12,
  parameter int FIFO_DEPTH                = 8,
  parameter int OVF_CNT_WIDTH             = 8
) (
  input  logic                                 CLK,
  input  logic                                 RST,
  input  logic                                 SPK_VALID,
  input  logic [POST_NEUR_PARALLEL-1:0]        SPK_VEC,
  input  logic [POST_NEUR_WORD_ADDR_WIDTH-1:0] SPK_WORD_ADDR,
  output logic                                 SPK_READY,
  output logic [AER_WIDTH-1:0]                 AEROUT_ADDR,
  output logic                                 AEROUT_REQ,
  input  logic                                 AEROUT_ACK,
  output logic [OVF_CNT_WIDTH-1:0]             OVF_CNT,
  output logic                                 BUSY
);
  localparam int P  = POST_NEUR_PARALLEL;
  localparam int WA = POST_NEUR_WORD_ADDR_WIDTH;
  localparam int BA = POST_NEUR_BYTE_ADDR_WIDTH;
  localparam int EW = WA + P;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_t;

  state_t          state;
  logic [WA-1:0]   wa;
  logic [P-1:0]    vec;
  logic [BA-1:0]   k;
  logic [AER_WIDTH-1:0] aer_next;
  logic            ack_meta;
  logic            ack_s;
  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [EW-1:0]   fifo_dat;
  logic            spk_nz;

  assign spk_nz    = SPK_VALID && (SPK_VEC != '0);
  assign fifo_push = spk_nz && !fifo_full;
  // Pop whenever the engine is ready for a new word: from IDLE, or at the end
  // of a handshake once the current word is exhausted.
  assign fifo_pop  = !fifo_empty &&
                     ((state == IDLE) ||
                      (state == WAIT_LO && !ack_s && vec == '0));

  spike_aer_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (CLK),
    .rst      (RST),
    .push     (fifo_push),
    .push_dat ({SPK_WORD_ADDR, SPK_VEC}),
    .pop      (fifo_pop),
    .pop_dat  (fifo_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign SPK_READY = !fifo_full;
  assign BUSY      = !fifo_empty || (state != IDLE);

  // Lowest set bit of the working vector; scanning downward lets the lowest index win.
  always_comb begin
    k = '0;
    for (int i = P - 1; i >= 0; i--) begin
      if (vec[i]) k = BA'(i);
    end
  end

  always_comb begin
    aer_next            = '0;
    aer_next[WA+BA-1:0] = {wa, k};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ack_meta <= 1'b0;
      ack_s    <= 1'b0;
    end else begin
      ack_meta <= AEROUT_ACK;
      ack_s    <= ack_meta;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      wa          <= '0;
      vec         <= '0;
      AEROUT_REQ  <= 1'b0;
      AEROUT_ADDR <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fifo_pop) begin
            {wa, vec} <= fifo_dat;
            state     <= SEND;
          end
        end
        SEND: begin
          AEROUT_ADDR <= aer_next;
          AEROUT_REQ  <= 1'b1;
          vec         <= vec & (vec - P'(1));  // clears the lowest set bit
          state       <= WAIT_HI;
        end
        WAIT_HI: begin
          if (ack_s) begin
            AEROUT_REQ <= 1'b0;
            state      <= WAIT_LO;
          end
        end
        WAIT_LO: begin
          if (!ack_s) begin
            if (vec != '0) begin
              state <= SEND;
            end else if (fifo_pop) begin
              {wa, vec} <= fifo_dat;
              state     <= SEND;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      OVF_CNT <= '0;
    end else if (spk_nz && fifo_full && (OVF_CNT != '1)) begin
      OVF_CNT <= OVF_CNT + 1'b1;
    end
  end
endmodule

// File: tb/tb_spike_aer_encoder.sv
module tb_spike_aer_encoder;
  logic        CLK;
  logic        RST;
  logic        SPK_VALID;
  logic [3:0]  SPK_VEC;
  logic [7:0]  SPK_WORD_ADDR;
  logic        SPK_READY;
  logic [11:0] AEROUT_ADDR;
  logic        AEROUT_REQ;
  logic        AEROUT_ACK;
  logic [7:0]  OVF_CNT;
  logic        BUSY;

  spike_aer_encoder dut (
    .CLK           (CLK),
    .RST           (RST),
    .SPK_VALID     (SPK_VALID),
    .SPK_VEC       (SPK_VEC),
    .SPK_WORD_ADDR (SPK_WORD_ADDR),
    .SPK_READY     (SPK_READY),
    .AEROUT_ADDR   (AEROUT_ADDR),
    .AEROUT_REQ    (AEROUT_REQ),
    .AEROUT_ACK    (AEROUT_ACK),
    .OVF_CNT       (OVF_CNT),
    .BUSY          (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int          n_vec = 0;
  int          n_err = 0;
  logic [11:0] exp_q [$];
  int          req_cnt = 0;
  logic        req_q = 1'b0;
  logic [11:0] cur_addr = '0;
  bit          chk_stable = 1'b0;
  bit          ack_auto = 1'b1;
  logic        ack_force = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drives one word for one cycle; accepted words queue their expected AER addresses.
  task automatic send_word(input logic [7:0] w, input logic [3:0] v, input bit acc);
    @(negedge CLK);
    SPK_VALID     = 1'b1;
    SPK_WORD_ADDR = w;
    SPK_VEC       = v;
    if (acc) begin
      for (int b = 0; b < 4; b++) begin
        if (v[b]) exp_q.push_back({2'b00, w, 2'(b)});
      end
    end
  endtask

  task automatic idle_inputs();
    @(negedge CLK);
    SPK_VALID = 1'b0;
    SPK_VEC   = '0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (!BUSY && exp_q.size() == 0) break;
    end
    check("drain_busy", 32'(BUSY), 32'd0);
    check("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  // ACK responder: follows REQ with a half-cycle lag, or holds a forced level.
  initial begin
    AEROUT_ACK = 1'b0;
    forever begin
      @(negedge CLK);
      if (ack_auto) AEROUT_ACK = AEROUT_REQ;
      else          AEROUT_ACK = ack_force;
    end
  end

  // Monitor: each REQ rise pops one expected address from the scoreboard.
  initial begin
    forever begin
      @(negedge CLK);
      if (AEROUT_REQ && !req_q) begin
        req_cnt++;
        cur_addr = AEROUT_ADDR;
        if (exp_q.size() == 0) check("req_unexpected", 32'(AEROUT_REQ), 32'd0);
        else                   check("aer_addr", 32'(AEROUT_ADDR), 32'(exp_q.pop_front()));
      end else if (chk_stable && (AEROUT_REQ || AEROUT_ACK)) begin
        check("addr_stable", 32'(AEROUT_ADDR), 32'(cur_addr));
      end
      req_q = AEROUT_REQ;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  r0;
    bit  busy_seen;

    RST = 1'b1;
    SPK_VALID = 1'b0;
    SPK_VEC = '0;
    SPK_WORD_ADDR = '0;
    #1;
    check("rst_ready", 32'(SPK_READY), 32'd1);
    check("rst_req",   32'(AEROUT_REQ), 32'd0);
    check("rst_addr",  32'(AEROUT_ADDR), 32'd0);
    check("rst_ovf",   32'(OVF_CNT), 32'd0);
    check("rst_busy",  32'(BUSY), 32'd0);
    repeat (3) @(negedge CLK);
    RST = 1'b0;

    // Single word, two set bits.
    r0 = req_cnt;
    send_word(8'h05, 4'b1010, 1'b1);
    idle_inputs();
    wait_drain(200);
    check("t1_req_pulses", 32'(req_cnt - r0), 32'd2);

    // Zero vectors are ignored.
    r0 = req_cnt;
    busy_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      send_word(8'h40 + 8'(i), 4'b0000, 1'b0);
      busy_seen |= BUSY;
    end
    idle_inputs();
    repeat (10) @(negedge CLK);
    busy_seen |= BUSY;
    check("t2_req_pulses", 32'(req_cnt - r0), 32'd0);
    check("t2_ovf", 32'(OVF_CNT), 32'd0);
    check("t2_busy_seen", 32'(busy_seen), 32'd0);

    // Full vector: four addresses, address stable over each handshake.
    chk_stable = 1'b1;
    send_word(8'hFF, 4'b1111, 1'b1);
    idle_inputs();
    wait_drain(300);
    chk_stable = 1'b0;

    // Overflow: engine stalled in a handshake, then 10 words back to back.
    ack_auto  = 1'b0;
    ack_force = 1'b0;
    send_word(8'h10, 4'b0001, 1'b1);
    idle_inputs();
    repeat (5) @(negedge CLK);
    for (int i = 0; i < 10; i++) begin
      send_word(8'h20 + 8'(i), 4'((i % 15) + 1), i < 8);
    end
    idle_inputs();
    check("t3_ready", 32'(SPK_READY), 32'd0);
    check("t3_ovf", 32'(OVF_CNT), 32'd2);
    ack_auto = 1'b1;
    wait_drain(2000);
    check("t3_ready_after", 32'(SPK_READY), 32'd1);

    // Saturation: fill the FIFO and throw 300 words at it.
    ack_auto  = 1'b0;
    ack_force = 1'b0;
    send_word(8'h30, 4'b0001, 1'b1);
    idle_inputs();
    repeat (5) @(negedge CLK);
    for (int i = 0; i < 8; i++) send_word(8'h50 + 8'(i), 4'b0100, 1'b1);
    for (int i = 0; i < 300; i++) send_word(8'h70, 4'b0010, 1'b0);
    idle_inputs();
    check("t6_ovf_sat", 32'(OVF_CNT), 32'd255);
    repeat (5) @(negedge CLK);
    check("t6_ovf_hold", 32'(OVF_CNT), 32'd255);

    // Reset while REQ=1 and ACK=1.
    ack_force = 1'b1;
    @(negedge CLK);
    #1;
    check("t5_pre_req", 32'(AEROUT_REQ), 32'd1);
    check("t5_pre_ack", 32'(AEROUT_ACK), 32'd1);
    RST = 1'b1;
    #1;
    check("t5_req", 32'(AEROUT_REQ), 32'd0);
    check("t5_ovf", 32'(OVF_CNT), 32'd0);
    check("t5_ready", 32'(SPK_READY), 32'd1);
    check("t5_busy", 32'(BUSY), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge CLK);
    ack_force = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    ack_auto = 1'b1;
    r0 = req_cnt;
    repeat (20) @(negedge CLK);
    check("t5_no_req", 32'(req_cnt - r0), 32'd0);
    check("t5_busy_after", 32'(BUSY), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
